// File: rtl/filter_mode_sequencer_pkg.sv
// Shared types and helpers for the filter mode sequencer.
// Holds the mode type, the FSM states and the mode-to-enable map.
package filter_seq_pkg;

    typedef logic [2:0] mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PENDING = 2'd2,
        APPLY   = 2'd3
    } seq_state_t;

    localparam int NUM_MODES_DEF      = 6;
    localparam int BEATS_PER_MODE_DEF = 16;

    // Returns {thresh, bright, adsr} for a mode; unreachable modes bypass everything.
    function automatic logic [2:0] mode_to_en(input mode_t m);
        logic [2:0] en;
        case (m)
            3'd0:    en = 3'b000;
            3'd1:    en = 3'b100;
            3'd2:    en = 3'b010;
            3'd3:    en = 3'b110;
            3'd4:    en = 3'b001;
            3'd5:    en = 3'b111;
            default: en = 3'b000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/filter_mode_sequencer_if.sv
// Signal bundle between the beat/BPM/key sources, the sequencer and the filter stages.
// The master side is the sequencer; the slave side is the surrounding pipeline.
interface filter_mode_sequencer_if;
    import filter_seq_pkg::*;

    logic       frame_start;
    logic       beat_in;
    logic       key_next;
    logic       auto_mode;
    logic [7:0] bpm_val;
    mode_t      mode;
    logic       thresh_en;
    logic       bright_en;
    logic       adsr_en;
    logic       adsr_trigger;
    logic       mode_changed;

    modport master (
        input  frame_start, beat_in, key_next, auto_mode, bpm_val,
        output mode, thresh_en, bright_en, adsr_en, adsr_trigger, mode_changed
    );

    modport slave (
        output frame_start, beat_in, key_next, auto_mode, bpm_val,
        input  mode, thresh_en, bright_en, adsr_en, adsr_trigger, mode_changed
    );

endinterface

// File: rtl/filter_mode_sequencer_sync_debounce.sv
// Two-flop synchronizer with an optional stable-count debouncer and a registered rise pulse.
// DEBOUNCE_CYCLES = 0 bypasses the debouncer so the stable level is the synced level.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic synced_lvl,
    output logic stable_lvl,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic stable_s;
    logic stable_d_r;
    logic rise_r;

    // Metastability guard for the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= async_in;
            sync2_r <= sync1_r;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable_s = sync2_r;
        end else begin : g_debounce
            localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_r;
            logic             stable_r;

            // Count consecutive samples that disagree with the stable level; flip once enough agree.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_r    <= {CNT_W{1'b0}};
                    stable_r <= 1'b0;
                end else if (sync2_r == stable_r) begin
                    cnt_r    <= {CNT_W{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    cnt_r    <= {CNT_W{1'b0}};
                    stable_r <= sync2_r;
                end else begin
                    cnt_r    <= cnt_r + CNT_W'(1);
                end
            end

            assign stable_s = stable_r;
        end
    endgenerate

    // Rising-edge detect on the stable level, registered so the pulse is exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_d_r <= 1'b0;
            rise_r     <= 1'b0;
        end else begin
            stable_d_r <= stable_s;
            rise_r     <= stable_s & ~stable_d_r;
        end
    end

    assign synced_lvl = sync2_r;
    assign stable_lvl = stable_s;
    assign rise       = rise_r;

endmodule

// File: rtl/filter_mode_sequencer.sv
// Selects the active filter stages and issues the ADSR beat trigger.
// Advances come from a debounced key or counted beats and are applied only on frame_start.
module filter_mode_sequencer
    import filter_seq_pkg::*;
#(
    parameter int NUM_MODES       = NUM_MODES_DEF,
    parameter int BEATS_PER_MODE  = BEATS_PER_MODE_DEF,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int MIN_BPM         = 40,
    parameter int MAX_BPM         = 200
) (
    input logic                    clk,
    input logic                    reset,
    filter_mode_sequencer_if.master bus
);

    localparam int BC_W = (BEATS_PER_MODE > 1) ? $clog2(BEATS_PER_MODE) : 1;
    localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BEATS_PER_MODE - 1);
    localparam mode_t           MODE_LAST = mode_t'(NUM_MODES - 1);

    logic            beat_rise_s;
    logic            key_press_s;
    logic            auto_d_r;
    logic            auto_change_s;
    logic            beat_ok_s;
    logic            beat_term_s;
    logic            adv_req_s;
    logic [BC_W-1:0] beat_count_r;
    seq_state_t      state_r;
    seq_state_t      state_next_s;
    mode_t           mode_r;
    mode_t           mode_next_s;
    logic            thresh_en_r;
    logic            bright_en_r;
    logic            adsr_en_r;
    logic            adsr_trigger_r;
    logic            mode_changed_r;

    sync_debounce #(.DEBOUNCE_CYCLES(0)) u_beat_sync (
        .clk        (clk),
        .reset      (reset),
        .async_in   (bus.beat_in),
        .synced_lvl (),
        .stable_lvl (),
        .rise       (beat_rise_s)
    );

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debounce (
        .clk        (clk),
        .reset      (reset),
        .async_in   (bus.key_next),
        .synced_lvl (),
        .stable_lvl (),
        .rise       (key_press_s)
    );

    assign auto_change_s = bus.auto_mode ^ auto_d_r;
    assign beat_ok_s     = beat_rise_s
                         & (bus.bpm_val >= 8'(MIN_BPM))
                         & (bus.bpm_val <= 8'(MAX_BPM));
    assign beat_term_s   = beat_ok_s & (beat_count_r == BC_LAST);
    assign mode_next_s   = (mode_r == MODE_LAST) ? 3'd0 : mode_r + 3'd1;

    // One-cycle advance request; a source switch swallows whatever arrives in that cycle.
    always_comb begin
        adv_req_s = 1'b0;
        if (auto_change_s) begin
            adv_req_s = 1'b0;
        end else if (bus.auto_mode) begin
            adv_req_s = beat_term_s;
        end else begin
            adv_req_s = key_press_s;
        end
    end

    // Mode FSM next state; PENDING holds a single advance until the frame boundary.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (adv_req_s) state_next_s = PENDING;
                else           state_next_s = IDLE;
            end
            RUN: begin
                if (adv_req_s) state_next_s = PENDING;
                else           state_next_s = RUN;
            end
            PENDING: begin
                if (auto_change_s)        state_next_s = RUN;
                else if (bus.frame_start) state_next_s = APPLY;
                else                      state_next_s = PENDING;
            end
            APPLY: begin
                if (adv_req_s) state_next_s = PENDING;
                else           state_next_s = RUN;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, mode and enable registers; enables are always loaded together with the mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            mode_r         <= 3'd0;
            thresh_en_r    <= 1'b0;
            bright_en_r    <= 1'b0;
            adsr_en_r      <= 1'b0;
            mode_changed_r <= 1'b0;
            adsr_trigger_r <= 1'b0;
            auto_d_r       <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            auto_d_r       <= bus.auto_mode;
            adsr_trigger_r <= beat_rise_s & adsr_en_r;
            if (state_r == APPLY) begin
                mode_r                                <= mode_next_s;
                {thresh_en_r, bright_en_r, adsr_en_r} <= mode_to_en(mode_next_s);
                mode_changed_r                        <= 1'b1;
            end else begin
                mode_changed_r <= 1'b0;
            end
        end
    end

    // Qualified beat counter for auto mode; out-of-range beats leave it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count_r <= {BC_W{1'b0}};
        end else if (auto_change_s) begin
            beat_count_r <= {BC_W{1'b0}};
        end else if (bus.auto_mode && beat_ok_s) begin
            if (beat_count_r == BC_LAST) beat_count_r <= {BC_W{1'b0}};
            else                         beat_count_r <= beat_count_r + BC_W'(1);
        end else begin
            beat_count_r <= beat_count_r;
        end
    end

    assign bus.mode         = mode_r;
    assign bus.thresh_en    = thresh_en_r;
    assign bus.bright_en    = bright_en_r;
    assign bus.adsr_en      = adsr_en_r;
    assign bus.adsr_trigger = adsr_trigger_r;
    assign bus.mode_changed = mode_changed_r;

endmodule

// File: tb/tb_filter_mode_sequencer.sv
// Directed bench for filter_mode_sequencer: a vector table of advance episodes plus
// hand-written sequences for timing, coincidence, trigger and reset corner cases.
module tb_filter_mode_sequencer;

    typedef struct {
        logic       auto_m;
        logic [7:0] bpm;
        int         presses;
        int         key_hi;
        int         beats;
        logic [2:0] exp_mode;
        logic [2:0] exp_en;
        int         exp_chg;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   mc_cnt = 0;
    int   trig_cnt = 0;
    vec_t vecs [13];

    filter_mode_sequencer_if bus ();

    filter_mode_sequencer #(
        .NUM_MODES       (6),
        .BEATS_PER_MODE  (4),
        .DEBOUNCE_CYCLES (4),
        .MIN_BPM         (40),
        .MAX_BPM         (200)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mode_changed === 1'b1) mc_cnt <= mc_cnt + 1;
        if (bus.adsr_trigger === 1'b1) trig_cnt <= trig_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic press_key(input int hi);
        bus.key_next = 1'b1;
        repeat (hi) tick();
        bus.key_next = 1'b0;
        repeat (12) tick();
    endtask

    task automatic send_beats(input int n);
        for (int b = 0; b < n; b++) begin
            bus.beat_in = 1'b1;
            repeat (3) tick();
            bus.beat_in = 1'b0;
            repeat (3) tick();
        end
        repeat (6) tick();
    endtask

    task automatic frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic advance_key();
        press_key(10);
        frame();
        repeat (6) tick();
    endtask

    function automatic int en_bits();
        return int'({bus.thresh_en, bus.bright_en, bus.adsr_en});
    endfunction

    initial begin
        int mc0;
        int tr0;

        vecs[0]  = '{1'b0, 8'd0,   1, 10, 0, 3'd1, 3'b100, 1};
        vecs[1]  = '{1'b0, 8'd0,   1,  3, 0, 3'd1, 3'b100, 0};
        vecs[2]  = '{1'b0, 8'd0,   3, 10, 0, 3'd2, 3'b010, 1};
        vecs[3]  = '{1'b1, 8'd120, 0,  0, 4, 3'd3, 3'b110, 1};
        vecs[4]  = '{1'b1, 8'd250, 0,  0, 8, 3'd3, 3'b110, 0};
        vecs[5]  = '{1'b1, 8'd120, 0,  0, 3, 3'd3, 3'b110, 0};
        vecs[6]  = '{1'b1, 8'd40,  0,  0, 1, 3'd4, 3'b001, 1};
        vecs[7]  = '{1'b1, 8'd200, 0,  0, 4, 3'd5, 3'b111, 1};
        vecs[8]  = '{1'b1, 8'd39,  0,  0, 4, 3'd5, 3'b111, 0};
        vecs[9]  = '{1'b0, 8'd120, 1, 10, 0, 3'd0, 3'b000, 1};
        vecs[10] = '{1'b0, 8'd120, 0,  0, 4, 3'd0, 3'b000, 0};
        vecs[11] = '{1'b1, 8'd201, 0,  0, 4, 3'd0, 3'b000, 0};
        vecs[12] = '{1'b1, 8'd120, 1, 10, 0, 3'd0, 3'b000, 0};

        reset           = 1'b1;
        bus.frame_start = 1'b0;
        bus.beat_in     = 1'b0;
        bus.key_next    = 1'b0;
        bus.auto_mode   = 1'b0;
        bus.bpm_val     = 8'd0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state, then idle frames must not change anything.
        chk("reset_mode", int'(bus.mode), 0);
        chk("reset_en", en_bits(), 0);
        chk("reset_mc", int'(bus.mode_changed), 0);
        chk("reset_trig", int'(bus.adsr_trigger), 0);
        for (int f = 0; f < 3; f++) begin
            repeat (5) tick();
            frame();
        end
        repeat (6) tick();
        chk("idle_mode", int'(bus.mode), 0);
        chk("idle_en", en_bits(), 0);
        chk("idle_mc_cnt", mc_cnt, 0);
        chk("idle_trig_cnt", trig_cnt, 0);

        for (int i = 0; i < 13; i++) begin
            mc0 = mc_cnt;
            bus.auto_mode = vecs[i].auto_m;
            bus.bpm_val   = vecs[i].bpm;
            repeat (4) tick();
            for (int p = 0; p < vecs[i].presses; p++) press_key(vecs[i].key_hi);
            send_beats(vecs[i].beats);
            frame();
            repeat (6) tick();
            chk($sformatf("vec%0d_mode", i), int'(bus.mode), int'(vecs[i].exp_mode));
            chk($sformatf("vec%0d_en", i), en_bits(), int'(vecs[i].exp_en));
            chk($sformatf("vec%0d_changes", i), mc_cnt - mc0, vecs[i].exp_chg);
        end

        // Apply latency: mode_changed appears exactly two edges after frame_start is sampled.
        bus.auto_mode = 1'b0;
        repeat (4) tick();
        press_key(10);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("lat_mc_edge1", int'(bus.mode_changed), 0);
        chk("lat_mode_edge1", int'(bus.mode), 0);
        tick();
        chk("lat_mc_edge2", int'(bus.mode_changed), 1);
        chk("lat_mode_edge2", int'(bus.mode), 1);
        chk("lat_en_edge2", en_bits(), 3'b100);
        tick();
        chk("lat_mc_width", int'(bus.mode_changed), 0);

        // Key press whose advance request lands on the same edge as frame_start.
        mc0 = mc_cnt;
        bus.key_next = 1'b1;
        repeat (7) tick();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        repeat (3) tick();
        bus.key_next = 1'b0;
        repeat (12) tick();
        chk("coinc_mode_held", int'(bus.mode), 1);
        chk("coinc_no_change", mc_cnt - mc0, 0);
        frame();
        repeat (6) tick();
        chk("coinc_mode_next", int'(bus.mode), 2);
        chk("coinc_changes", mc_cnt - mc0, 1);

        // Switching auto_mode drops a pending advance and clears the beat count.
        mc0 = mc_cnt;
        bus.auto_mode = 1'b1;
        bus.bpm_val   = 8'd120;
        repeat (4) tick();
        send_beats(4);
        bus.auto_mode = 1'b0;
        repeat (4) tick();
        frame();
        repeat (6) tick();
        chk("autosw_pending_drop", int'(bus.mode), 2);
        bus.auto_mode = 1'b1;
        repeat (4) tick();
        send_beats(2);
        bus.auto_mode = 1'b0;
        repeat (4) tick();
        bus.auto_mode = 1'b1;
        repeat (4) tick();
        send_beats(2);
        frame();
        repeat (6) tick();
        chk("autosw_count_clear", int'(bus.mode), 2);
        chk("autosw_no_change", mc_cnt - mc0, 0);
        send_beats(2);
        frame();
        repeat (6) tick();
        chk("autosw_count_resume", int'(bus.mode), 3);
        bus.auto_mode = 1'b0;
        repeat (4) tick();

        // ADSR trigger timing in mode 4: one-cycle pulse four edges after the first high sample.
        advance_key();
        chk("trig_mode4", int'(bus.mode), 4);
        chk("trig_en4", en_bits(), 3'b001);
        bus.beat_in = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk($sformatf("trig_cyc%0d", c), int'(bus.adsr_trigger), (c == 4) ? 1 : 0);
        end
        bus.beat_in = 1'b0;
        repeat (6) tick();

        // Wrap 4 -> 5 -> 0 -> 1, then a beat in mode 1 must not trigger.
        advance_key();
        advance_key();
        chk("wrap_mode0", int'(bus.mode), 0);
        advance_key();
        chk("mode1_again", int'(bus.mode), 1);
        tr0 = trig_cnt;
        send_beats(1);
        repeat (4) tick();
        chk("mode1_no_trig", trig_cnt - tr0, 0);

        // Asynchronous reset while an advance is pending.
        press_key(10);
        chk("pend_mode_held", int'(bus.mode), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_mode", int'(bus.mode), 0);
        chk("async_rst_en", en_bits(), 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        mc0 = mc_cnt;
        frame();
        repeat (6) tick();
        chk("post_rst_mode", int'(bus.mode), 0);
        chk("post_rst_no_change", mc_cnt - mc0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
